// File: rtl/countdown_timer.sv
// Loadable down-counter with valid/ready reload, one-shot or periodic operation,
// pause/stop control and a registered one-cycle expiry pulse.
module countdown_timer #(
    parameter int unsigned CW               = 16,
    parameter int unsigned PERIODIC_DEFAULT = 0
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_load_valid,
    output logic          o_load_ready,
    input  logic [CW-1:0] i_load_value,
    input  logic          i_start,
    input  logic          i_stop,
    input  logic          i_pause,
    input  logic          i_periodic,
    output logic [CW-1:0] o_count,
    output logic          o_busy,
    output logic          o_expired
);

    // PERIODIC_DEFAULT only exists for tie-offs above this block; reject nonsense values.
    if (PERIODIC_DEFAULT > 1) begin : g_param_check
        $error("countdown_timer: PERIODIC_DEFAULT must be 0 or 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_RUN,
        S_PAUSE
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] reload_q, reload_d;
    logic          have_reload_q, have_reload_d;
    logic          expired_q, expired_d;
    logic          load_fire;

    assign o_load_ready = (state_q == S_IDLE) || (state_q == S_ARMED);
    assign o_busy       = (state_q == S_RUN) || (state_q == S_PAUSE);
    assign o_count      = count_q;
    assign o_expired    = expired_q;
    assign load_fire    = i_load_valid && o_load_ready;

    // Priority chain: stop > load > start > pause/count.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d       = state_q;
        count_d       = count_q;
        reload_d      = reload_q;
        have_reload_d = have_reload_q;
        expired_d     = 1'b0;

        if (i_stop) begin
            state_d = S_IDLE;
        end else if (load_fire) begin
            reload_d      = i_load_value;
            count_d       = i_load_value;
            have_reload_d = 1'b1;
            state_d       = S_ARMED;
        end else if (i_start && (state_q == S_ARMED)) begin
            state_d = S_RUN;
        end else if (i_start && (state_q == S_IDLE) && have_reload_q) begin
            count_d = reload_q;
            state_d = S_RUN;
        end else begin
            unique case (state_q)
                S_RUN: begin
                    if (i_pause) begin
                        state_d = S_PAUSE;
                    end else if (count_q != '0) begin
                        count_d = count_q - CW'(1);
                    end else begin
                        expired_d = 1'b1;
                        if (i_periodic) begin
                            count_d = reload_q;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
                // Resuming costs one cycle: no decrement on the return edge.
                S_PAUSE: begin
                    if (!i_pause) begin
                        state_d = S_RUN;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= S_IDLE;
            count_q       <= '0;
            reload_q      <= '0;
            have_reload_q <= 1'b0;
            expired_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q       <= state_d;
            count_q       <= count_d;
            reload_q      <= reload_d;
            have_reload_q <= have_reload_d;
            expired_q     <= expired_d;
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: expected outputs are queued as each step is
// driven and popped/compared once the clock edge has produced the DUT response.
module tb_countdown_timer;

    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load_valid = 1'b0;
    logic          load_ready;
    logic [CW-1:0] load_value = '0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          pause = 1'b0;
    logic          periodic = 1'b0;
    logic [CW-1:0] count;
    logic          busy;
    logic          expired;

    typedef struct packed {
        logic [CW-1:0] count;
        logic          busy;
        logic          ready;
        logic          expired;
    } obs_t;

    obs_t  exp_q[$];
    string tag_q[$];
    int    tests = 0;
    int    fails = 0;
    int    model_cnt;
    logic  model_exp;

    countdown_timer #(
        .CW              (CW),
        .PERIODIC_DEFAULT(0)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_load_valid(load_valid),
        .o_load_ready(load_ready),
        .i_load_value(load_value),
        .i_start     (start),
        .i_stop      (stop),
        .i_pause     (pause),
        .i_periodic  (periodic),
        .o_count     (count),
        .o_busy      (busy),
        .o_expired   (expired)
    );

    always #5 clk = ~clk;

    task automatic expect_out(input string tag, input logic [CW-1:0] c, input logic b,
                              input logic r, input logic x);
        obs_t e;
        e.count   = c;
        e.busy    = b;
        e.ready   = r;
        e.expired = x;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic check_now();
        obs_t  e;
        obs_t  o;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        o.count   = count;
        o.busy    = busy;
        o.ready   = load_ready;
        o.expired = expired;
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s: observed count=%0d busy=%b ready=%b expired=%b, expected count=%0d busy=%b ready=%b expired=%b",
                   t, o.count, o.busy, o.ready, o.expired, e.count, e.busy, e.ready, e.expired);
        end
    endtask

    // Drive one cycle of inputs, queue the expected post-edge outputs, then compare.
    task automatic cyc(input string tag, input logic lv, input logic [CW-1:0] lval,
                       input logic st, input logic sp, input logic pa,
                       input logic [CW-1:0] c, input logic b, input logic r, input logic x);
        @(negedge clk);
        load_valid = lv;
        load_value = lval;
        start      = st;
        stop       = sp;
        pause      = pa;
        expect_out(tag, c, b, r, x);
        @(posedge clk);
        #1;
        check_now();
    endtask

    initial begin
        // Reset state while rst_n is held low.
        #1;
        expect_out("reset", '0, 1'b0, 1'b1, 1'b0);
        check_now();
        #11 rst_n = 1'b1;

        // One-shot: load 5, count 5..0, expire, back to IDLE.
        periodic = 1'b0;
        cyc("os_load",  1, 16'd5, 0, 0, 0, 16'd5, 0, 1, 0);
        cyc("os_start", 0, '0,    1, 0, 0, 16'd5, 1, 0, 0);
        for (int v = 4; v >= 0; v--)
            cyc("os_count", 0, '0, 0, 0, 0, CW'(v), 1, 0, 0);
        cyc("os_expire", 0, '0, 0, 0, 0, 16'd0, 0, 1, 1);
        cyc("os_idle",   0, '0, 0, 0, 0, 16'd0, 0, 1, 0);

        // Periodic with reload 3: pulse every 4 cycles.
        periodic = 1'b1;
        cyc("per_load",  1, 16'd3, 0, 0, 0, 16'd3, 0, 1, 0);
        cyc("per_start", 0, '0,    1, 0, 0, 16'd3, 1, 0, 0);
        model_cnt = 3;
        for (int i = 0; i < 12; i++) begin
            if (model_cnt == 0) begin
                model_cnt = 3;
                model_exp = 1'b1;
            end else begin
                model_cnt--;
                model_exp = 1'b0;
            end
            cyc("per_run", 0, '0, 0, 0, 0, CW'(model_cnt), 1, 0, model_exp);
        end
        cyc("per_stop", 0, '0, 0, 1, 0, 16'd3, 0, 1, 0);

        // Pause at count 2: held for three cycles, expiry on edge 8 instead of 5.
        periodic = 1'b0;
        cyc("pz_load",   1, 16'd4, 0, 0, 0, 16'd4, 0, 1, 0);
        cyc("pz_start",  0, '0,    1, 0, 0, 16'd4, 1, 0, 0);
        cyc("pz_c3",     0, '0,    0, 0, 0, 16'd3, 1, 0, 0);
        cyc("pz_c2",     0, '0,    0, 0, 0, 16'd2, 1, 0, 0);
        cyc("pz_hold1",  0, '0,    0, 0, 1, 16'd2, 1, 0, 0);
        cyc("pz_hold2",  0, '0,    0, 0, 1, 16'd2, 1, 0, 0);
        cyc("pz_resume", 0, '0,    0, 0, 0, 16'd2, 1, 0, 0);
        cyc("pz_c1",     0, '0,    0, 0, 0, 16'd1, 1, 0, 0);
        cyc("pz_c0",     0, '0,    0, 0, 0, 16'd0, 1, 0, 0);
        cyc("pz_expire", 0, '0,    0, 0, 0, 16'd0, 0, 1, 1);

        // Restart from IDLE reuses reload 4; pause and stop at count 0 suppress expiry.
        cyc("rs_start",  0, '0, 1, 0, 0, 16'd4, 1, 0, 0);
        for (int v = 3; v >= 0; v--)
            cyc("rs_count", 0, '0, 0, 0, 0, CW'(v), 1, 0, 0);
        cyc("z_pause",   0, '0, 0, 0, 1, 16'd0, 1, 0, 0);
        cyc("z_paused",  0, '0, 0, 0, 1, 16'd0, 1, 0, 0);
        cyc("z_resume",  0, '0, 0, 0, 0, 16'd0, 1, 0, 0);
        cyc("z_stop",    0, '0, 0, 1, 0, 16'd0, 0, 1, 0);
        cyc("rs_again",  0, '0, 1, 0, 0, 16'd4, 1, 0, 0);
        cyc("rs_c3",     0, '0, 0, 0, 0, 16'd3, 1, 0, 0);
        cyc("rs_stop",   0, '0, 0, 1, 0, 16'd3, 0, 1, 0);

        // Reload 0 periodic: pulse every cycle; loads refused while running.
        periodic = 1'b1;
        cyc("r0_load",    1, 16'd0, 0, 0, 0, 16'd0, 0, 1, 0);
        cyc("r0_start",   0, '0,    1, 0, 0, 16'd0, 1, 0, 0);
        for (int i = 0; i < 3; i++)
            cyc("r0_pulse", 0, '0, 0, 0, 0, 16'd0, 1, 0, 1);
        cyc("r0_load_busy", 1, 16'd9, 0, 0, 0, 16'd0, 1, 0, 1);
        cyc("r0_stop",    0, '0,    0, 1, 0, 16'd0, 0, 1, 0);
        periodic = 1'b0;
        cyc("r0_restart", 0, '0,    1, 0, 0, 16'd0, 1, 0, 0);
        cyc("r0_oneshot", 0, '0,    0, 0, 0, 16'd0, 0, 1, 1);

        // Load and start together: load wins; a second load in ARMED overwrites.
        cyc("ls_both",  1, 16'd7, 1, 0, 0, 16'd7, 0, 1, 0);
        cyc("ls_over",  1, 16'd2, 0, 0, 0, 16'd2, 0, 1, 0);
        cyc("ls_start", 0, '0,    1, 0, 0, 16'd2, 1, 0, 0);
        cyc("ls_stop",  0, '0,    0, 1, 0, 16'd2, 0, 1, 0);

        // Asynchronous reset mid-count at 7 of 10.
        cyc("ar_load",  1, 16'd10, 0, 0, 0, 16'd10, 0, 1, 0);
        cyc("ar_start", 0, '0,     1, 0, 0, 16'd10, 1, 0, 0);
        for (int v = 9; v >= 7; v--)
            cyc("ar_count", 0, '0, 0, 0, 0, CW'(v), 1, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        expect_out("ar_async", '0, 1'b0, 1'b1, 1'b0);
        check_now();
        @(negedge clk);
        rst_n = 1'b1;
        cyc("ar_noreload", 0, '0, 1, 0, 0, 16'd0, 0, 1, 0);
        cyc("ar_load1",    1, 16'd1, 0, 0, 0, 16'd1, 0, 1, 0);
        cyc("ar_start1",   0, '0,    1, 0, 0, 16'd1, 1, 0, 0);
        cyc("ar_c0",       0, '0,    0, 0, 0, 16'd0, 1, 0, 0);
        cyc("ar_expire",   0, '0,    0, 0, 0, 16'd0, 0, 1, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
